// File: rtl/poly_arith_pkg.sv
// Shared arithmetic types and constants for the polynomial datapath (modulus, coefficient type,
// polynomial length) plus the poly_sub_ctrl state encoding.
package poly_arith_pkg;

    localparam int Q          = 3329;
    localparam int COEFF_W    = 12;
    localparam int N_COEFF    = 256;
    localparam int IDX_W      = $clog2(N_COEFF);
    localparam int CNT_W      = IDX_W + 1;
    localparam int SUB_LAT    = 2;
    localparam int FIFO_DEPTH = 4;

    typedef logic [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} poly_sub_state_e;

    // With both operands below Q, the wrapped 12-bit difference plus Q lands back in 0..Q-1.
    function automatic coeff_t sub_mod_q(input coeff_t a, input coeff_t b);
        return (a >= b) ? coeff_t'(a - b) : coeff_t'(a - b + coeff_t'(Q));
    endfunction

endpackage

// File: rtl/coeff_fifo.sv
// Synchronous coefficient FIFO with an occupancy count; output reads as zero while empty.
module coeff_fifo
    import poly_arith_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  coeff_t        push_data,
    input  logic          pop,
    output logic          valid,
    output coeff_t        data,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    coeff_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: storage is left unreset; only pointers and count need a known value, and the
    // output mux hides stale entries while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != '0);
    assign data  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/mod_sub.sv
// Fixed-latency (a-b) mod Q pipeline; cannot stall, valid_o follows valid_i by LAT cycles.
module mod_sub
    import poly_arith_pkg::*;
#(
    parameter int LAT = SUB_LAT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   valid_i,
    input  coeff_t op1_i,
    input  coeff_t op2_i,
    output logic   valid_o,
    output coeff_t result_o
);

    logic [LAT-1:0] vld;
    coeff_t         pipe [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= valid_i;
            for (int i = 1; i < LAT; i++) vld[i] <= vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe[0] <= sub_mod_q(op1_i, op2_i);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign valid_o  = vld[LAT-1];
    assign result_o = pipe[LAT-1];

endmodule

// File: rtl/poly_sub_ctrl.sv
// Sequences one polynomial of operand pairs through mod_sub with credit-based flow control.
// Optional input range checking on err_o is enabled by defining POLY_SUB_RANGE_CHK_EN.
module poly_sub_ctrl
    import poly_arith_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic             ab_valid_i,
    output logic             ab_ready_o,
    input  coeff_t           a_i,
    input  coeff_t           b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output coeff_t           res_o,
    output logic [IDX_W-1:0] res_idx_o,
    output logic             res_last_o,
    output logic             err_o
);

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < SUB_LAT + 1) begin : g_depth_chk
        $error("FIFO_DEPTH must be at least SUB_LAT+1");
    end

    poly_sub_state_e  state;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] pop_cnt;
    logic [OCC_W-1:0] inflight;
    logic [OCC_W-1:0] fifo_cnt;
    logic [OCC_W:0]   occupancy;
    logic             issue;
    logic             pop;
    logic             last_pop;
    logic             sub_valid;
    coeff_t           sub_res;

    // Every issued pair holds a FIFO slot from issue until pop, so a push can never overflow.
    assign occupancy  = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign ab_ready_o = (state == RUN) && (issue_cnt < CNT_W'(N_COEFF))
                        && (occupancy < (OCC_W + 1)'(FIFO_DEPTH));
    assign issue      = ab_valid_i && ab_ready_o;
    assign pop        = res_valid_o && res_ready_i;
    assign last_pop   = pop && (pop_cnt == CNT_W'(N_COEFF - 1));
    assign res_idx_o  = pop_cnt[IDX_W-1:0];
    assign res_last_o = res_valid_o && (pop_cnt == CNT_W'(N_COEFF - 1));

    mod_sub #(.LAT(SUB_LAT)) u_mod_sub (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (issue),
        .op1_i    (a_i),
        .op2_i    (b_i),
        .valid_o  (sub_valid),
        .result_o (sub_res)
    );

    coeff_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sub_valid),
        .push_data (sub_res),
        .pop       (pop),
        .valid     (res_valid_o),
        .data      (res_o),
        .count     (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, sub_valid})
                2'b10:   inflight <= inflight + OCC_W'(1);
                2'b01:   inflight <= inflight - OCC_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Counter updates come first so the start branch below can override them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            issue_cnt <= '0;
            pop_cnt   <= '0;
        end else begin
            done_o <= 1'b0;
            if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
            if (pop)   pop_cnt   <= pop_cnt + CNT_W'(1);
            case (state)
                IDLE: if (start_i) begin
                    state     <= RUN;
                    busy_o    <= 1'b1;
                    issue_cnt <= '0;
                    pop_cnt   <= '0;
                end
                RUN: if (issue_cnt == CNT_W'(N_COEFF)) state <= DRAIN;
                DRAIN: if (last_pop) begin
                    state  <= DONE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef POLY_SUB_RANGE_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (state == IDLE && start_i) begin
            err_o <= 1'b0;
        end else if (issue && (a_i >= coeff_t'(Q) || b_i >= coeff_t'(Q))) begin
            err_o <= 1'b1;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule
